regfile_wb: RTL and testbench
=============================

Name: regfile_wb

Overview:
- General-purpose register file for the 5-stage MIPS32 pipeline.
- It is the write-back end of the memory/write-back pipeline register: it consumes the registered wb_wd/wb_wreg/wb_wdata triplet and commits it to architectural state.
- It also serves the two operand read ports used by the decode stage.
- It includes write-to-read bypass, $zero hardwiring and a commit counter for debug and performance visibility.

Parameters:
- NUM_REGS, 32, number of architectural registers; power of two.
- ADDR_W, 5, register address width; log2(NUM_REGS).
- DATA_W, 32, register data width.
- CNT_W, 32, width of the commit counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- wb_wd  in  ADDR_W  destination register address from the write-back stage.
- wb_wreg  in  1  write enable from the write-back stage.
- wb_wdata  in  DATA_W  write data from the write-back stage.
- re1  in  1  read-port-1 enable.
- raddr1  in  ADDR_W  read-port-1 address.
- rdata1  out  DATA_W  read-port-1 data.
- re2  in  1  read-port-2 enable.
- raddr2  in  ADDR_W  read-port-2 address.
- rdata2  out  DATA_W  read-port-2 data.
- commit_cnt  out  CNT_W  count of committed non-$zero writes.
- last_wd  out  ADDR_W  address of the most recent committed write.
- last_wdata  out  DATA_W  data of the most recent committed write.

Behaviour:
Reset:
- While rst=1, asynchronously:
  - all NUM_REGS entries = 0
  - commit_cnt = 0
  - last_wd = 0
  - last_wdata = 0
  - rdata1 = rdata2 = 0, regardless of any read inputs.
- Deassertion takes effect at the next clk edge. No write commits on an edge where rst=1.
- Reset asserted mid-operation discards any write presented that cycle.

Write:
- At a rising clk edge with rst=0, wb_wreg=1 and wb_wd!=0, the register at wb_wd is set to wb_wdata.
- On that same edge:
  - commit_cnt increments by 1; it wraps modulo 2^CNT_W with no saturation.
  - last_wd is set to wb_wd.
  - last_wdata is set to wb_wdata.
- A write with wb_wd=0 is ignored entirely: no register change, no counter increment, no last_* update.
- wb_wreg=0 means no effect, whatever the address and data inputs hold.
- Register 0 always reads 0 and is never written.

Read (combinational, zero latency), evaluated independently per port, in priority order:
1. rst=1 -> 0.
2. re=0 -> 0.
3. raddr=0 -> 0.
4. raddr==wb_wd, wb_wreg=1 and wb_wd!=0 -> wb_wdata (same-cycle bypass, so decode sees the value being written this cycle).
5. Otherwise -> stored register value.

Simultaneous events:
- Both ports may address the same register as each other and as the write; both return the bypassed data.
- The write commits at the edge independently of reads.

Widths:
- Addresses are compared at full ADDR_W.
- No sign or zero extension; data is passed through unchanged.

Test Plan:
1. Reset: assert rst asynchronously mid-cycle after filling r5=32'hDEADBEEF -> rdata1/2=0 immediately; after release, read r5 -> 0; commit_cnt=0.
2. Basic write/read: wb_wreg=1, wb_wd=5'd3, wb_wdata=32'h12345678, one edge; then re1=1, raddr1=3 -> rdata1=32'h12345678; commit_cnt=1; last_wd=3; last_wdata=32'h12345678.
3. $zero: write wb_wd=0, wb_wdata=32'hFFFFFFFF -> read r0 returns 0; commit_cnt unchanged; last_wd unchanged.
4. Bypass: with r7=32'h1, present wb_wd=7, wb_wdata=32'hA5A5A5A5, wb_wreg=1, and raddr1=raddr2=7 with both re=1 in the same cycle -> both ports return 32'hA5A5A5A5 before the edge; r7 holds it after the edge.
5. Enable gating:
   - re1=0 with raddr1=3 holding data -> rdata1=0.
   - wb_wreg=0, wb_wd=3, wb_wdata=32'h0 -> r3 keeps its prior value and no bypass occurs.
6. Counter wrap: CNT_W=4, perform 17 non-zero writes -> commit_cnt=1; interleaved wb_wd=0 writes do not count.

Source files
------------

// File: rtl/regfile_wb.sv
// regfile_wb: MIPS32 general-purpose register file at the write-back end of
// the pipeline. It has one synchronous write port fed by the MEM/WB register
// and two combinational read ports for decode. A write that is presented in
// the current cycle is forwarded to the read ports. Register $zero always
// reads as zero. Every real commit is counted and the most recent one is
// latched so that debug logic can observe it.
module regfile_wb #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] wb_wd,
    input  logic              wb_wreg,
    input  logic [DATA_W-1:0] wb_wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic [CNT_W-1:0]  commit_cnt,
    output logic [ADDR_W-1:0] last_wd,
    output logic [DATA_W-1:0] last_wdata
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    // A commit needs an enabled write to a nonzero address. Writes to $zero
    // are dropped completely, so they affect neither the counter nor last_*.
    logic commit;
    assign commit = wb_wreg && (wb_wd != '0);

    // Architectural state, commit counter and last-commit record. The
    // counter wraps naturally because it has a fixed width.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            commit_cnt <= '0;
            last_wd    <= '0;
            last_wdata <= '0;
        end else if (commit) begin
            regs[wb_wd] <= wb_wdata;
            commit_cnt  <= commit_cnt + 1'b1;
            last_wd     <= wb_wd;
            last_wdata  <= wb_wdata;
        end
    end

    // Read port 1 in priority order: reset, disabled, $zero, same-cycle
    // bypass, then the stored value.
    always_comb begin
        rdata1 = '0;
        if (rst || !re1 || (raddr1 == '0)) begin
            rdata1 = '0;
        end else if (commit && (raddr1 == wb_wd)) begin
            rdata1 = wb_wdata;
        end else begin
            rdata1 = regs[raddr1];
        end
    end

    // Read port 2 uses the same priority order as port 1 but is evaluated
    // independently of it.
    always_comb begin
        rdata2 = '0;
        if (rst || !re2 || (raddr2 == '0)) begin
            rdata2 = '0;
        end else if (commit && (raddr2 == wb_wd)) begin
            rdata2 = wb_wdata;
        end else begin
            rdata2 = regs[raddr2];
        end
    end

endmodule

// File: tb/tb_regfile_wb.sv
// tb_regfile_wb: self-checking bench for regfile_wb. It drives a 32-bit
// counter instance and a 4-bit counter instance from the same inputs.
module tb_regfile_wb;

    logic        clk;
    logic        rst;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic        re2;
    logic [4:0]  raddr2;

    logic [31:0] rdata1, rdata2, commit_cnt, last_wdata;
    logic [4:0]  last_wd;
    logic [31:0] rdata1_s, rdata2_s, last_wdata_s;
    logic [3:0]  commit_cnt_s;
    logic [4:0]  last_wd_s;

    regfile_wb #(.CNT_W(32)) u_dut (
        .clk(clk), .rst(rst), .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
        .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
        .commit_cnt(commit_cnt), .last_wd(last_wd), .last_wdata(last_wdata)
    );

    regfile_wb #(.CNT_W(4)) u_dut_small (
        .clk(clk), .rst(rst), .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1_s),
        .re2(re2), .raddr2(raddr2), .rdata2(rdata2_s),
        .commit_cnt(commit_cnt_s), .last_wd(last_wd_s), .last_wdata(last_wdata_s)
    );

    // ---------------- clock / reset block ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    logic [31:0] m_regs [32];
    logic [31:0] m_cnt;
    logic [4:0]  m_last_wd;
    logic [31:0] m_last_wdata;
    logic        m_rst;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_cnt        = '0;
        m_last_wd    = '0;
        m_last_wdata = '0;
    endtask

    function automatic logic [31:0] model_read(input logic re, input logic [4:0] a);
        if (m_rst) return '0;
        if (!re) return '0;
        if (a == 5'd0) return '0;
        if (wb_wreg && (wb_wd != 5'd0) && (a == wb_wd)) return wb_wdata;
        return m_regs[a];
    endfunction

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic push_reads();
        logic [31:0] e1, e2;
        e1 = model_read(re1, raddr1);
        e2 = model_read(re2, raddr2);
        exp_q.push_back(e1);
        exp_q.push_back(e2);
        exp_q.push_back(e1);
        exp_q.push_back(e2);
    endtask

    task automatic pop_reads(input string tag);
        if (exp_q.size() < 4) begin
            check({tag, "_qempty"}, 32'(exp_q.size()), 32'd4);
        end else begin
            check({tag, "_rd1"},   rdata1,   exp_q.pop_front());
            check({tag, "_rd2"},   rdata2,   exp_q.pop_front());
            check({tag, "_rd1_s"}, rdata1_s, exp_q.pop_front());
            check({tag, "_rd2_s"}, rdata2_s, exp_q.pop_front());
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_cnt"},    commit_cnt,             m_cnt);
        check({tag, "_cnt_s"},  {28'd0, commit_cnt_s}, {28'd0, m_cnt[3:0]});
        check({tag, "_lwd"},    {27'd0, last_wd},       {27'd0, m_last_wd});
        check({tag, "_lwdata"}, last_wdata,             m_last_wdata);
    endtask

    // ---------------- driver ----------------
    // Entered and left one time unit after a rising edge. The task drives
    // the inputs, checks the reads in mid-cycle, clocks once and then checks
    // the committed state.
    task automatic apply(input string tag,
                         input logic w, input logic [4:0] wd, input logic [31:0] wdata,
                         input logic r1, input logic [4:0] a1,
                         input logic r2, input logic [4:0] a2);
        wb_wreg = w; wb_wd = wd; wb_wdata = wdata;
        re1 = r1; raddr1 = a1; re2 = r2; raddr2 = a2;
        #1;
        push_reads();
        #3;
        pop_reads(tag);
        @(posedge clk);
        if (w && wd != 5'd0) begin
            m_regs[wd]   = wdata;
            m_cnt        = m_cnt + 1;
            m_last_wd    = wd;
            m_last_wdata = wdata;
        end
        #1;
        check_state(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1; m_rst = 1'b1;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0; m_rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; m_rst = 1'b1;
        wb_wd = '0; wb_wreg = 1'b0; wb_wdata = '0;
        re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
        model_reset();
        do_reset();
        check_state("reset_init");

        // Test 1: fill r5, then assert reset asynchronously in mid-cycle.
        apply("fill_r5", 1, 5'd5, 32'hDEADBEEF, 1, 5'd5, 0, 5'd0);
        apply("read_r5", 0, 5'd0, 32'h0, 1, 5'd5, 1, 5'd5);
        wb_wreg = 1'b1; wb_wd = 5'd9; wb_wdata = 32'h55;
        re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd9;
        #2;
        rst = 1'b1; m_rst = 1'b1;
        model_reset();
        #1;
        push_reads();
        pop_reads("async_rst");
        check_state("async_rst");
        @(posedge clk);
        #1;
        check_state("rst_edge");
        rst = 1'b0; m_rst = 1'b0;
        apply("post_rst", 0, 5'd0, 32'h0, 1, 5'd5, 1, 5'd9);

        // Test 2: a basic write followed by a read.
        apply("wr_r3", 1, 5'd3, 32'h12345678, 0, 5'd0, 0, 5'd0);
        apply("rd_r3", 0, 5'd0, 32'h0, 1, 5'd3, 0, 5'd3);

        // Test 3: a write to $zero has no effect.
        apply("wr_r0", 1, 5'd0, 32'hFFFFFFFF, 1, 5'd0, 1, 5'd0);
        apply("rd_r0", 0, 5'd0, 32'h0, 1, 5'd0, 1, 5'd3);

        // Test 4: same-cycle bypass on both ports.
        apply("wr_r7", 1, 5'd7, 32'h1, 0, 5'd0, 0, 5'd0);
        apply("byp_r7", 1, 5'd7, 32'hA5A5A5A5, 1, 5'd7, 1, 5'd7);
        check("byp_exact", rdata1, 32'hA5A5A5A5);
        apply("rd_r7", 0, 5'd0, 32'h0, 1, 5'd7, 1, 5'd7);

        // Test 5: read enables and write enable gate their ports.
        apply("re_off", 0, 5'd0, 32'h0, 0, 5'd3, 1, 5'd3);
        apply("wreg_off", 0, 5'd3, 32'h0, 1, 5'd3, 1, 5'd3);
        apply("rd_r3_keep", 0, 5'd0, 32'h0, 1, 5'd3, 0, 5'd0);

        // Test 6: wrap of the 4-bit counter. Writes to $zero are interleaved
        // and must not be counted.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            apply("wrap_w", 1, 5'(1 + (i % 31)), 32'(i * 3 + 1), 1, 5'(1 + (i % 31)), 1, 5'd1);
            apply("wrap_z", 1, 5'd0, 32'hCAFE0000 | 32'(i), 1, 5'd0, 1, 5'd2);
        end
        check("wrap_cnt_s", {28'd0, commit_cnt_s}, 32'd1);
        check("wrap_cnt", commit_cnt, 32'd17);

        // Random traffic on all ports.
        for (int i = 0; i < 200; i++) begin
            apply("rand",
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
        end

        check("q_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
